// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: definitions shared by the HI/LO controller and its staging buffer.
//   hilo_state_t : controller state (IDLE = staging empty, PEND = staging holds a result)
//   MT_SEL_LO/HI : encoding of the MTHI/MTLO target select
package hilo_ctrl_pkg;

  typedef enum logic {
    HILO_IDLE = 1'b0,
    HILO_PEND = 1'b1
  } hilo_state_t;

  localparam logic MT_SEL_LO = 1'b0;
  localparam logic MT_SEL_HI = 1'b1;

endpackage

// File: rtl/hilo_ctrl_stage.sv
// hilo_stage: one-entry staging buffer for a HI/LO result with per-half valid bits.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_clear             drop the entry (highest priority)
//   i_load              stage new data; halves selected by i_hi_we / i_lo_we
//   i_retire            entry has been written back; empty the buffer
//   i_hi, i_lo          data to stage
//   o_hi, o_lo          staged data
//   o_hi_v, o_lo_v      per-half valid bits
module hilo_stage #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic         i_retire,
  input  logic         i_hi_we,
  input  logic         i_lo_we,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo,
  output logic         o_hi_v,
  output logic         o_lo_v
);

  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic         r_hi_v;
  logic         r_lo_v;

  // Load takes precedence over retire so that a commit and a new accept on
  // the same edge retire the old entry and stage the new one together.
  // A half not written by a load keeps stale data but loses its valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_hi_v <= 1'b0;
      r_lo_v <= 1'b0;
    end else if (i_clear) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_hi_v <= 1'b0;
      r_lo_v <= 1'b0;
    end else if (i_load) begin
      if (i_hi_we) r_hi <= i_hi;
      if (i_lo_we) r_lo <= i_lo;
      r_hi_v <= i_hi_we;
      r_lo_v <= i_lo_we;
    end else if (i_retire) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_hi_v <= 1'b0;
      r_lo_v <= 1'b0;
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_hi_v = r_hi_v;
  assign o_lo_v = r_lo_v;

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: owns the architectural HI/LO registers. Results from the divider,
// the multiplier and MTHI/MTLO are held in a one-entry staging buffer until the
// producing instruction commits in M, or dropped on an M-stage exception.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   div_res_valid/ready, div_result {remainder, quotient} -> {HI, LO}
//   mul_valid, mul_result {hi, lo}   held by requester until accepted
//   mt_we, mt_sel, mt_data           MTHI/MTLO request, held until accepted
//   commit             owner of the staged result commits this cycle
//   flush_exceptionM   discard staged and incoming results
//   hi_o, lo_o         forwarded HI/LO for MFHI/MFLO
//   stall_hilo         stall while a new result waits on an uncommitted entry
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           div_res_valid,
  output logic           div_res_ready,
  input  logic [2*W-1:0] div_result,
  input  logic           mul_valid,
  input  logic [2*W-1:0] mul_result,
  input  logic           mt_we,
  input  logic           mt_sel,
  input  logic [W-1:0]   mt_data,
  input  logic           commit,
  input  logic           flush_exceptionM,
  output logic [W-1:0]   hi_o,
  output logic [W-1:0]   lo_o,
  output logic           stall_hilo
);

  hilo_state_t r_state;
  hilo_state_t w_state_nxt;

  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;

  logic         w_pend;
  logic         w_acc;
  logic         w_div_hs;
  logic         w_take_mul;
  logic         w_take_mt;
  logic         w_load;
  logic         w_commit_ok;
  logic         w_clear;
  logic         w_retire;
  logic         w_ld_hi_we;
  logic         w_ld_lo_we;
  logic [W-1:0] w_ld_hi;
  logic [W-1:0] w_ld_lo;

  logic [W-1:0] w_stg_hi;
  logic [W-1:0] w_stg_lo;
  logic         w_stg_hi_v;
  logic         w_stg_lo_v;

  assign w_pend = (r_state == HILO_PEND);

  // Gated by rst so the handshake cannot complete while reset is held.
  assign w_acc = ((~w_pend) | (w_pend & commit)) & ~flush_exceptionM & ~rst;

  assign w_div_hs   = div_res_valid & w_acc;
  assign w_take_mul = w_acc & ~div_res_valid & mul_valid;
  assign w_take_mt  = w_acc & ~div_res_valid & ~mul_valid & mt_we;
  assign w_load     = w_div_hs | w_take_mul | w_take_mt;

  assign w_commit_ok = w_pend & commit & ~flush_exceptionM;
  assign w_clear     = w_pend & flush_exceptionM;
  assign w_retire    = w_commit_ok & ~w_load;

  always_comb begin
    w_ld_hi_we = 1'b0;
    w_ld_lo_we = 1'b0;
    w_ld_hi    = '0;
    w_ld_lo    = '0;
    if (w_div_hs) begin
      w_ld_hi_we = 1'b1;
      w_ld_lo_we = 1'b1;
      w_ld_hi    = div_result[2*W-1:W];
      w_ld_lo    = div_result[W-1:0];
    end else if (w_take_mul) begin
      w_ld_hi_we = 1'b1;
      w_ld_lo_we = 1'b1;
      w_ld_hi    = mul_result[2*W-1:W];
      w_ld_lo    = mul_result[W-1:0];
    end else if (w_take_mt) begin
      w_ld_hi_we = (mt_sel == MT_SEL_HI);
      w_ld_lo_we = (mt_sel == MT_SEL_LO);
      w_ld_hi    = mt_data;
      w_ld_lo    = mt_data;
    end
  end

  hilo_stage #(.W(W)) u_stage (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .i_retire (w_retire),
    .i_hi_we  (w_ld_hi_we),
    .i_lo_we  (w_ld_lo_we),
    .i_hi     (w_ld_hi),
    .i_lo     (w_ld_lo),
    .o_hi     (w_stg_hi),
    .o_lo     (w_stg_lo),
    .o_hi_v   (w_stg_hi_v),
    .o_lo_v   (w_stg_lo_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= HILO_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HILO_IDLE: begin
        if (w_load) w_state_nxt = HILO_PEND;
      end
      HILO_PEND: begin
        if (flush_exceptionM)  w_state_nxt = HILO_IDLE;
        else if (commit)       w_state_nxt = w_load ? HILO_PEND : HILO_IDLE;
      end
      default: w_state_nxt = HILO_IDLE;
    endcase
  end

  // Architectural write-back of the valid staged halves at commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit_ok) begin
      if (w_stg_hi_v) r_hi <= w_stg_hi;
      if (w_stg_lo_v) r_lo <= w_stg_lo;
    end
  end

  assign hi_o = (w_pend & w_stg_hi_v) ? w_stg_hi : r_hi;
  assign lo_o = (w_pend & w_stg_lo_v) ? w_stg_lo : r_lo;

  assign div_res_ready = w_acc;
  assign stall_hilo    = w_pend & ~commit & ~flush_exceptionM & ~rst &
                         (mul_valid | mt_we | div_res_valid);

endmodule

// File: tb/tb_hilo_ctrl.sv
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           div_res_valid;
  logic           div_res_ready;
  logic [2*W-1:0] div_result;
  logic           mul_valid;
  logic [2*W-1:0] mul_result;
  logic           mt_we;
  logic           mt_sel;
  logic [W-1:0]   mt_data;
  logic           commit;
  logic           flush_exceptionM;
  logic [W-1:0]   hi_o;
  logic [W-1:0]   lo_o;
  logic           stall_hilo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hilo_ctrl #(.W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .div_res_valid    (div_res_valid),
    .div_res_ready    (div_res_ready),
    .div_result       (div_result),
    .mul_valid        (mul_valid),
    .mul_result       (mul_result),
    .mt_we            (mt_we),
    .mt_sel           (mt_sel),
    .mt_data          (mt_data),
    .commit           (commit),
    .flush_exceptionM (flush_exceptionM),
    .hi_o             (hi_o),
    .lo_o             (lo_o),
    .stall_hilo       (stall_hilo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    div_res_valid = 1'b0; div_result = '0;
    mul_valid = 1'b0; mul_result = '0;
    mt_we = 1'b0; mt_sel = 1'b0; mt_data = '0;
    commit = 1'b0; flush_exceptionM = 1'b0;
    step(); step();
    chk("rst_hi_o", 64'(hi_o), 64'h0);
    chk("rst_lo_o", 64'(lo_o), 64'h0);
    chk("rst_ready", 64'(div_res_ready), 64'h0);
    chk("rst_stall", 64'(stall_hilo), 64'h0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(div_res_ready), 64'h1);

    // Divider {3,5}, commit one cycle later
    div_res_valid = 1'b1; div_result = {32'h3, 32'h5};
    #1;
    chk("div_acc_ready", 64'(div_res_ready), 64'h1);
    step();
    div_res_valid = 1'b0;
    #1;
    chk("div_hi_fwd", 64'(hi_o), 64'h3);
    chk("div_lo_fwd", 64'(lo_o), 64'h5);
    chk("div_arch_hi_pre", 64'(dut.r_hi), 64'h0);
    chk("pend_ready", 64'(div_res_ready), 64'h0);
    commit = 1'b1;
    #1;
    chk("commit_ready", 64'(div_res_ready), 64'h1);
    step();
    commit = 1'b0;
    #1;
    chk("div_arch_hi", 64'(dut.r_hi), 64'h3);
    chk("div_arch_lo", 64'(dut.r_lo), 64'h5);
    chk("div_hi_post", 64'(hi_o), 64'h3);
    chk("div_lo_post", 64'(lo_o), 64'h5);
    chk("div_state_idle", 64'(dut.r_state), 64'(HILO_IDLE));

    // Divider {9,8} then flush in PEND
    div_res_valid = 1'b1; div_result = {32'h9, 32'h8};
    step();
    div_res_valid = 1'b0;
    #1;
    chk("fl_hi_fwd", 64'(hi_o), 64'h9);
    flush_exceptionM = 1'b1;
    #1;
    chk("fl_ready", 64'(div_res_ready), 64'h0);
    step();
    flush_exceptionM = 1'b0;
    #1;
    chk("fl_hi_o", 64'(hi_o), 64'h3);
    chk("fl_lo_o", 64'(lo_o), 64'h5);
    chk("fl_state", 64'(dut.r_state), 64'(HILO_IDLE));
    chk("fl_arch_hi", 64'(dut.r_hi), 64'h3);

    // MTLO 7 committed, then MTHI AA
    mt_we = 1'b1; mt_sel = MT_SEL_LO; mt_data = 32'h7;
    step();
    mt_we = 1'b0; commit = 1'b1;
    step();
    commit = 1'b0;
    #1;
    chk("mtlo_arch_lo", 64'(dut.r_lo), 64'h7);
    chk("mtlo_arch_hi", 64'(dut.r_hi), 64'h3);
    mt_we = 1'b1; mt_sel = MT_SEL_HI; mt_data = 32'hAA;
    step();
    mt_we = 1'b0;
    #1;
    chk("mthi_hi_fwd", 64'(hi_o), 64'hAA);
    chk("mthi_lo_fwd", 64'(lo_o), 64'h7);
    chk("mthi_lo_v", 64'(dut.u_stage.o_lo_v), 64'h0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    #1;
    chk("mthi_arch_hi", 64'(dut.r_hi), 64'hAA);
    chk("mthi_arch_lo", 64'(dut.r_lo), 64'h7);
    chk("mthi_hi_post", 64'(hi_o), 64'hAA);
    chk("mthi_lo_post", 64'(lo_o), 64'h7);

    // Stall while mul waits on an uncommitted MTLO 0x11
    mt_we = 1'b1; mt_sel = MT_SEL_LO; mt_data = 32'h11;
    step();
    mt_we = 1'b0;
    mul_valid = 1'b1; mul_result = {32'hC, 32'hD};
    #1;
    chk("st_stall", 64'(stall_hilo), 64'h1);
    chk("st_ready", 64'(div_res_ready), 64'h0);
    step();
    chk("st_hold_lo", 64'(lo_o), 64'h11);
    chk("st_hold_hi", 64'(hi_o), 64'hAA);
    chk("st_stall2", 64'(stall_hilo), 64'h1);
    commit = 1'b1;
    #1;
    chk("st_commit_stall", 64'(stall_hilo), 64'h0);
    chk("st_commit_ready", 64'(div_res_ready), 64'h1);
    step();
    commit = 1'b0; mul_valid = 1'b0;
    #1;
    chk("st_arch_lo", 64'(dut.r_lo), 64'h11);
    chk("st_arch_hi", 64'(dut.r_hi), 64'hAA);
    chk("st_state_pend", 64'(dut.r_state), 64'(HILO_PEND));
    chk("st_mul_hi", 64'(hi_o), 64'hC);
    chk("st_mul_lo", 64'(lo_o), 64'hD);
    chk("st_stall_off", 64'(stall_hilo), 64'h0);

    // Commit and flush together: flush wins
    commit = 1'b1; flush_exceptionM = 1'b1;
    step();
    commit = 1'b0; flush_exceptionM = 1'b0;
    #1;
    chk("cf_arch_hi", 64'(dut.r_hi), 64'hAA);
    chk("cf_arch_lo", 64'(dut.r_lo), 64'h11);
    chk("cf_state", 64'(dut.r_state), 64'(HILO_IDLE));
    chk("cf_hi_v", 64'(dut.u_stage.o_hi_v), 64'h0);
    chk("cf_hi_o", 64'(hi_o), 64'hAA);

    // Priority and back-to-back: div > mul > mt, one per cycle with commit
    div_res_valid = 1'b1; div_result = {32'h1, 32'h2};
    mul_valid = 1'b1; mul_result = {32'hE, 32'hF};
    mt_we = 1'b1; mt_sel = MT_SEL_HI; mt_data = 32'h55;
    step();
    div_res_valid = 1'b0;
    #1;
    chk("pr_div_hi", 64'(hi_o), 64'h1);
    chk("pr_div_lo", 64'(lo_o), 64'h2);
    commit = 1'b1;
    #1;
    chk("bb_stall0", 64'(stall_hilo), 64'h0);
    step();
    mul_valid = 1'b0;
    #1;
    chk("bb_mul_hi", 64'(hi_o), 64'hE);
    chk("bb_mul_lo", 64'(lo_o), 64'hF);
    chk("bb_arch_hi1", 64'(dut.r_hi), 64'h1);
    step();
    mt_we = 1'b0;
    #1;
    chk("bb_mt_hi", 64'(hi_o), 64'h55);
    chk("bb_mt_lo", 64'(lo_o), 64'hF);
    chk("bb_arch_lo2", 64'(dut.r_lo), 64'hF);
    step();
    commit = 1'b0;
    #1;
    chk("bb_arch_hi3", 64'(dut.r_hi), 64'h55);

    // Asynchronous reset mid-PEND with staged {1,2}
    div_res_valid = 1'b1; div_result = {32'h1, 32'h2};
    step();
    div_res_valid = 1'b0; mul_valid = 1'b1;
    #1;
    chk("ar_hi_pre", 64'(hi_o), 64'h1);
    chk("ar_stall_pre", 64'(stall_hilo), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_hi_o", 64'(hi_o), 64'h0);
    chk("ar_lo_o", 64'(lo_o), 64'h0);
    chk("ar_ready", 64'(div_res_ready), 64'h0);
    chk("ar_stall", 64'(stall_hilo), 64'h0);
    mul_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("ar_rel_ready", 64'(div_res_ready), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
